// File: rtl/hvsync_ram_sync.sv
// hvsync_ram_sync
// Video-timing generator for a 256x240 raster plus a single-port synchronous
// RAM for sprite attribute storage, both clocked by the same pixel clock.
//
// Ports:
//   clk        in   pixel/system clock, rising edge
//   reset      in   synchronous, active-high
//   hpos       out  9-bit horizontal beam counter (0..H_MAX)
//   vpos       out  9-bit vertical beam counter (0..V_MAX)
//   hsync      out  registered horizontal sync, active-high
//   vsync      out  registered vertical sync, active-high
//   display_on out  combinational visible-area flag
//   ram_addr   in   RAM address
//   ram_din    in   RAM write data
//   ram_we     in   RAM write enable
//   ram_dout   out  registered RAM read data (1-clock latency)
//
// Build option:
//   RAM_WRITE_THROUGH_EN  defined   -> write-first (ram_dout shows ram_din on a write)
//                         undefined -> read-first  (ram_dout shows the old word)

module hvsync_ram_sync #(
  parameter int unsigned H_DISPLAY  = 256,
  parameter int unsigned H_FRONT    = 7,
  parameter int unsigned H_SYNC     = 23,
  parameter int unsigned H_BACK     = 23,
  parameter int unsigned V_DISPLAY  = 240,
  parameter int unsigned V_BOTTOM   = 14,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_TOP      = 5,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [8:0]            hpos,
  output logic [8:0]            vpos,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  display_on,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_din,
  input  logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] H_VIS        = 9'(H_DISPLAY);
  localparam logic [8:0] V_VIS        = 9'(V_DISPLAY);
  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Beam counters and sync
  // ---------------------------------------------------------------------------
  logic [8:0] r_hpos, r_vpos;
  logic       r_hsync, r_vsync;
  logic [8:0] w_hpos_d, w_vpos_d;
  logic       w_hwrap, w_vwrap;
  logic       w_hsync_d, w_vsync_d;

  always_comb begin
    w_hwrap   = (r_hpos == H_MAX);
    w_vwrap   = (r_vpos == V_MAX);
    w_hpos_d  = r_hpos + 9'd1;
    w_vpos_d  = r_vpos;
    if (w_hwrap) begin
      w_hpos_d = '0;
      // vpos steps only on the cycle hpos wraps
      w_vpos_d = w_vwrap ? '0 : r_vpos + 9'd1;
    end
    // Sync decodes come from the current counter values, so the registered
    // pulses trail the counters by one clock.
    w_hsync_d = (r_hpos >= H_SYNC_START) && (r_hpos <= H_SYNC_END);
    w_vsync_d = (r_vpos >= V_SYNC_START) && (r_vpos <= V_SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos  <= '0;
      r_vpos  <= '0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_hpos  <= w_hpos_d;
      r_vpos  <= w_vpos_d;
      r_hsync <= w_hsync_d;
      r_vsync <= w_vsync_d;
    end
  end

  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign display_on = (r_hpos < H_VIS) && (r_vpos < V_VIS);

  // ---------------------------------------------------------------------------
  // Sprite attribute RAM
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_ram_dout;

  // Memory array has no reset; writes proceed even while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      r_mem[ram_addr] <= ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_dout <= '0;
    end else begin
`ifdef RAM_WRITE_THROUGH_EN
      r_ram_dout <= ram_we ? ram_din : r_mem[ram_addr];
`else
      r_ram_dout <= r_mem[ram_addr];
`endif
    end
  end

  assign ram_dout = r_ram_dout;

endmodule

// File: tb/tb_hvsync_ram_sync.sv
// Self-checking bench for hvsync_ram_sync. Counter/sync expectations come from
// the elapsed clock count since reset; the RAM is tracked in a plain array.
module tb_hvsync_ram_sync;

  localparam int unsigned HTOT = 256 + 7 + 23 + 23;  // 309 clocks per line
  localparam int unsigned VTOT = 240 + 14 + 3 + 5;   // 262 lines per frame
  localparam int unsigned HSS  = 263;
  localparam int unsigned HSE  = 285;
  localparam int unsigned VSS  = 254;
  localparam int unsigned VSE  = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  hpos, vpos;
  logic        hsync, vsync, display_on;
  logic [5:0]  ram_addr = '0;
  logic [15:0] ram_din = '0;
  logic        ram_we = 1'b0;
  logic [15:0] ram_dout;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int unsigned t;             // clocks elapsed since the last reset edge
  logic [15:0] m_mem [64];
  bit          m_val [64];
  logic [15:0] exp_dout;
  bit          exp_known;
  logic [15:0] reset_word;

  hvsync_ram_sync dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  function automatic int unsigned eh(input int unsigned tt);
    return tt % HTOT;
  endfunction
  function automatic int unsigned ev(input int unsigned tt);
    return (tt / HTOT) % VTOT;
  endfunction
  function automatic logic ehs(input int unsigned tt);
    if (tt == 0) return 1'b0;
    return (eh(tt - 1) >= HSS) && (eh(tt - 1) <= HSE);
  endfunction
  function automatic logic evs(input int unsigned tt);
    if (tt == 0) return 1'b0;
    return (ev(tt - 1) >= VSS) && (ev(tt - 1) <= VSE);
  endfunction
  function automatic logic edisp(input int unsigned tt);
    return (eh(tt) < 256) && (ev(tt) < 240);
  endfunction

  // One clock: advance the model with the inputs in force at the edge, then
  // return on the falling edge where outputs are sampled and inputs changed.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      t = 0;
      exp_dout = '0;
      exp_known = 1'b1;
    end else begin
      t = t + 1;
`ifdef RAM_WRITE_THROUGH_EN
      if (ram_we) begin
        exp_dout = ram_din;
        exp_known = 1'b1;
      end else begin
        exp_dout = m_mem[ram_addr];
        exp_known = m_val[ram_addr];
      end
`else
      exp_dout = m_mem[ram_addr];
      exp_known = m_val[ram_addr];
`endif
    end
    if (ram_we) begin
      m_mem[ram_addr] = ram_din;
      m_val[ram_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_we = 1'b1;
    ram_addr = 6'd7;
    reset_word = 16'($urandom);
    ram_din = reset_word;
    repeat (3) tick();
    ram_we = 1'b0;
    reset = 1'b0;
    checks++; if (hpos !== 9'd0) begin failures++; $display("FAIL reset_hpos got=%0d want=0", hpos); end
    checks++; if (vpos !== 9'd0) begin failures++; $display("FAIL reset_vpos got=%0d want=0", vpos); end
    checks++; if (hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%b want=0", hsync); end
    checks++; if (vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync got=%b want=0", vsync); end
    checks++; if (display_on !== 1'b1) begin failures++; $display("FAIL reset_display got=%b want=1", display_on); end
    checks++; if (ram_dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h want=0000", ram_dout); end
  endtask

  task automatic test_line_wrap();
    repeat (308) tick();
    checks++; if (hpos !== 9'd308) begin failures++; $display("FAIL line_end_hpos got=%0d want=308", hpos); end
    checks++; if (vpos !== 9'd0) begin failures++; $display("FAIL line_end_vpos got=%0d want=0", vpos); end
    tick();
    checks++; if (hpos !== 9'(eh(t))) begin failures++; $display("FAIL wrap_hpos got=%0d want=%0d", hpos, eh(t)); end
    checks++; if (vpos !== 9'(ev(t))) begin failures++; $display("FAIL wrap_vpos got=%0d want=%0d", vpos, ev(t)); end
    checks++; if (hsync !== ehs(t)) begin failures++; $display("FAIL wrap_hsync got=%b want=%b", hsync, ehs(t)); end
  endtask

  task automatic test_midreset();
    int guard = 0;
    while (!(eh(t) == 150 && ev(t) == 2) && guard < 2000) begin
      tick();
      guard++;
    end
    checks++;
    if (hpos !== 9'd150 || vpos !== 9'd2) begin
      failures++;
      $display("FAIL midreset_pos got=(%0d,%0d) want=(2,150)", vpos, hpos);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (hpos !== 9'd0) begin failures++; $display("FAIL midreset_hpos got=%0d want=0", hpos); end
    checks++; if (vpos !== 9'd0) begin failures++; $display("FAIL midreset_vpos got=%0d want=0", vpos); end
    checks++; if (hsync !== 1'b0) begin failures++; $display("FAIL midreset_hsync got=%b want=0", hsync); end
    checks++; if (vsync !== 1'b0) begin failures++; $display("FAIL midreset_vsync got=%b want=0", vsync); end
  endtask

  task automatic test_ram_basic();
    ram_we = 1'b0; ram_addr = 6'd7; tick();
    checks++; if (ram_dout !== reset_word) begin failures++; $display("FAIL ram_write_in_reset got=%h want=%h", ram_dout, reset_word); end
    ram_we = 1'b1; ram_addr = 6'd5; ram_din = 16'h1234; tick();
    ram_we = 1'b0; tick();
    checks++; if (ram_dout !== 16'h1234) begin failures++; $display("FAIL ram_addr5 got=%h want=1234", ram_dout); end
    ram_we = 1'b1; ram_addr = 6'd63; ram_din = 16'hBEEF; tick();
    ram_we = 1'b0; tick();
    checks++; if (ram_dout !== 16'hBEEF) begin failures++; $display("FAIL ram_addr63 got=%h want=beef", ram_dout); end
  endtask

  task automatic test_rdw();
    logic [15:0] want;
`ifdef RAM_WRITE_THROUGH_EN
    want = 16'h5555;
`else
    want = 16'hAAAA;
`endif
    ram_we = 1'b1; ram_addr = 6'd2; ram_din = 16'hAAAA; tick();
    ram_din = 16'h5555; tick();
    checks++; if (ram_dout !== want) begin failures++; $display("FAIL rdw_dout got=%h want=%h", ram_dout, want); end
    ram_we = 1'b0; tick();
    checks++; if (ram_dout !== 16'h5555) begin failures++; $display("FAIL rdw_after got=%h want=5555", ram_dout); end
  endtask

  task automatic test_ram_random();
    for (int i = 0; i < 400; i++) begin
      ram_we = 1'($urandom_range(0, 1));
      ram_addr = 6'($urandom_range(0, 63));
      ram_din = 16'($urandom);
      tick();
      if (exp_known) begin
        checks++;
        if (ram_dout !== exp_dout) begin
          failures++;
          $display("FAIL ram_random i=%0d got=%h want=%h", i, ram_dout, exp_dout);
        end
      end
    end
    ram_we = 1'b0;
  endtask

  task automatic test_frame();
    int bad_h = 0, bad_v = 0, bad_hs = 0, bad_vs = 0, bad_d = 0;
    int hs_first = -1, hs_last = -1, hs_cnt = 0, line0_disp = 0, border_disp = 0;
    int vmax = 0, vs_rise_v = -1, vs_rise_h = -1, vs_fall_v = -1, vs_fall_h = -1;
    logic prev_vs = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n <= 80958; n++) begin
      if (n > 0) tick();
      if (hpos !== 9'(eh(t))) bad_h++;
      if (vpos !== 9'(ev(t))) bad_v++;
      if (hsync !== ehs(t)) bad_hs++;
      if (vsync !== evs(t)) bad_vs++;
      if (display_on !== edisp(t)) bad_d++;
      if (n < 309) begin
        if (hsync === 1'b1) begin
          if (hs_first < 0) hs_first = int'(hpos);
          hs_last = int'(hpos);
          hs_cnt++;
        end
        if (display_on === 1'b1) line0_disp++;
      end
      if (vpos >= 9'd240 && display_on === 1'b1) border_disp++;
      if (int'(vpos) > vmax) vmax = int'(vpos);
      if (vsync === 1'b1 && prev_vs === 1'b0 && vs_rise_v < 0) begin
        vs_rise_v = int'(vpos); vs_rise_h = int'(hpos);
      end
      if (vsync === 1'b0 && prev_vs === 1'b1 && vs_fall_v < 0) begin
        vs_fall_v = int'(vpos); vs_fall_h = int'(hpos);
      end
      prev_vs = vsync;
    end
    checks++; if (bad_h != 0) begin failures++; $display("FAIL frame_hpos mismatched_cycles=%0d want=0", bad_h); end
    checks++; if (bad_v != 0) begin failures++; $display("FAIL frame_vpos mismatched_cycles=%0d want=0", bad_v); end
    checks++; if (bad_hs != 0) begin failures++; $display("FAIL frame_hsync mismatched_cycles=%0d want=0", bad_hs); end
    checks++; if (bad_vs != 0) begin failures++; $display("FAIL frame_vsync mismatched_cycles=%0d want=0", bad_vs); end
    checks++; if (bad_d != 0) begin failures++; $display("FAIL frame_display mismatched_cycles=%0d want=0", bad_d); end
    checks++;
    if (hs_first != 264 || hs_last != 286 || hs_cnt != 23) begin
      failures++;
      $display("FAIL hsync_window got=first %0d last %0d count %0d want=264 286 23", hs_first, hs_last, hs_cnt);
    end
    checks++; if (line0_disp != 256) begin failures++; $display("FAIL line0_display got=%0d want=256", line0_disp); end
    checks++; if (border_disp != 0) begin failures++; $display("FAIL border_display got=%0d want=0", border_disp); end
    checks++; if (vmax != 261) begin failures++; $display("FAIL vpos_max got=%0d want=261", vmax); end
    checks++;
    if (vs_rise_v != 254 || vs_rise_h != 1) begin
      failures++;
      $display("FAIL vsync_rise got=(%0d,%0d) want=(254,1)", vs_rise_v, vs_rise_h);
    end
    checks++;
    if (vs_fall_v != 257 || vs_fall_h != 1) begin
      failures++;
      $display("FAIL vsync_fall got=(%0d,%0d) want=(257,1)", vs_fall_v, vs_fall_h);
    end
    checks++;
    if (hpos !== 9'd0 || vpos !== 9'd0) begin
      failures++;
      $display("FAIL frame_period got=(%0d,%0d) want=(0,0)", vpos, hpos);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    t = 0;
    exp_dout = '0;
    exp_known = 1'b0;
    @(negedge clk);
    test_reset();
    test_line_wrap();
    test_midreset();
    test_ram_basic();
    test_rdw();
    test_ram_random();
    test_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
